// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: rv32i_pkg with the fetch packet type and bubble NOP shared by the IF/ID queue
package rv32i_pkg;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_pkt_t;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle; slave is the queue side, master is the core side
interface if_id_queue_if;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        flush;
   logic        fetch_stall;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   modport master (output if_pc, if_inst, flush, id_ready,
                   input  fetch_stall, id_valid, id_pc, id_inst);
   modport slave  (input  if_pc, if_inst, flush, id_ready,
                   output fetch_stall, id_valid, id_pc, id_inst);
endinterface

// File: rtl/if_id_queue_fifo.sv
// ifq_fifo: synchronous circular FIFO of fetch packets with clear, occupancy count and registered head
module ifq_fifo
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  fetch_pkt_t    din,
   output logic [CW-1:0] count,
   output fetch_pkt_t    head
);
   fetch_pkt_t    mem_q [DEPTH];
   fetch_pkt_t    mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // next-state: clear empties the queue, otherwise push writes the tail and pop advances the head
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (clear) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = din;
            wr_d        = inc(wr_q);
         end
         if (pop) rd_d = inc(rd_q);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // state registers, zeroed on reset so the head reads as all-zero until the first push
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_q];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode queue pairing each PC with next-cycle imem data, with stall and flush.
// Define IF_ID_BUBBLE_NOP_EN to present PC 0 / NOP on id_pc/id_inst whenever id_valid is low.
module if_id_queue
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic          clk,
   input logic          reset,
   if_id_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(DEPTH + 2);

   logic          inflight_q, inflight_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count;
   logic [SW-1:0] occ;
   logic          valid, stall, issue, push, pop;
   fetch_pkt_t    head;

   // occupancy including the fetch in flight decides the stall; flush outranks push, pop and issue
   always_comb begin
      valid      = count != '0;
      pop        = valid && bus.id_ready && !bus.flush;
      push       = inflight_q && !bus.flush;
      occ        = SW'(count) + SW'(inflight_q) - SW'(pop);
      stall      = !bus.flush && (occ >= SW'(DEPTH));
      issue      = !bus.flush && !stall;
      inflight_d = issue;
      pc_d       = issue ? bus.if_pc : pc_q;
   end

   // remembers the PC whose instruction word arrives from imem next cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_q <= 1'b0;
         pc_q       <= '0;
      end else begin
         inflight_q <= inflight_d;
         pc_q       <= pc_d;
      end
   end

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (bus.flush),
      .din   ({pc_q, bus.if_inst}),
      .count (count),
      .head  (head)
   );

   assign bus.fetch_stall = stall;
   assign bus.id_valid    = valid;
`ifdef IF_ID_BUBBLE_NOP_EN
   assign bus.id_pc       = valid ? head.pc : '0;
   assign bus.id_inst     = valid ? head.inst : NOP_INST;
`else
   assign bus.id_pc       = head.pc;
   assign bus.id_inst     = head.inst;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and randomized checks of the IF/ID queue against a fetch-order model
module tb_if_id_queue;
   import rv32i_pkg::*;
   localparam int          DEPTH = 2;
   localparam logic [31:0] K     = 32'hA5A5_A5A5;
`ifdef IF_ID_BUBBLE_NOP_EN
   localparam logic [31:0] RST_INST = NOP_INST;
`else
   localparam logic [31:0] RST_INST = 32'h0;
`endif
   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          errors = 0;
   bit          run = 1'b0;
   logic [31:0] target = '0;
   logic [31:0] q [$];

   if_id_queue_if bus ();
   if_id_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic st, fl, pop;
      logic [31:0] pc, e;
      st  = bus.fetch_stall;
      fl  = bus.flush;
      pc  = bus.if_pc;
      pop = bus.id_valid && bus.id_ready && !fl;
      if (run) begin
         if (pop) begin
            chkb("pop_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("pop_pc", bus.id_pc, e);
               chk("pop_inst", bus.id_inst, e ^ K);
            end
         end
         if (fl) q.delete();
         else if (!st) q.push_back(pc);
      end
      @(posedge clk);
      #1;
      bus.if_inst = pc ^ K;
      bus.if_pc   = fl ? target : (st ? pc : pc + 32'd4);
      if (run) chkb("occupancy", q.size() <= DEPTH, 1'b1);
   endtask

   task automatic cyc(input logic rdy, input logic fl);
      tick();
      bus.id_ready = rdy;
      bus.flush    = fl;
      #1;
   endtask

   initial begin
      bus.if_pc    = '0;
      bus.if_inst  = '0;
      bus.flush    = 1'b0;
      bus.id_ready = 1'b0;
      #2 reset = 1'b0;
      repeat (4) begin
         tick();
         bus.if_pc    = $urandom;
         bus.if_inst  = $urandom;
         bus.flush    = 1'($urandom);
         bus.id_ready = 1'($urandom);
         #1;
         chkb("rst_valid", bus.id_valid, 1'b0);
         chkb("rst_stall", bus.fetch_stall, 1'b0);
         chk("rst_pc", bus.id_pc, 32'h0);
         chk("rst_inst", bus.id_inst, RST_INST);
      end
      reset        = 1'b1;
      bus.if_pc    = '0;
      bus.flush    = 1'b0;
      bus.id_ready = 1'b1;
      run          = 1'b1;
      #1;
      chkb("c0_valid", bus.id_valid, 1'b0);
      chkb("c0_stall", bus.fetch_stall, 1'b0);
      cyc(1'b1, 1'b0);
      chkb("c1_valid", bus.id_valid, 1'b0);
      for (int n = 2; n <= 7; n++) begin
         cyc(1'b1, 1'b0);
         chkb("stream_valid", bus.id_valid, 1'b1);
         chk("stream_pc", bus.id_pc, 32'(4 * (n - 2)));
         chk("stream_inst", bus.id_inst, 32'(4 * (n - 2)) ^ K);
         chkb("stream_stall", bus.fetch_stall, 1'b0);
      end
      for (int n = 8; n <= 13; n++) begin
         cyc(1'b0, 1'b0);
         chkb("bp_valid", bus.id_valid, 1'b1);
         chk("bp_pc", bus.id_pc, 32'h18);
         chkb("bp_stall", bus.fetch_stall, 1'b1);
      end
      for (int n = 14; n <= 17; n++) begin
         cyc(1'b1, 1'b0);
         chk("drain_pc", bus.id_pc, 32'(32'h18 + 4 * (n - 14)));
         chk("drain_inst", bus.id_inst, 32'(32'h18 + 4 * (n - 14)) ^ K);
         chkb("drain_stall", bus.fetch_stall, 1'b0);
      end
      target = 32'h100;
      cyc(1'b0, 1'b1);
      chk("fl_head", bus.id_pc, 32'h28);
      chkb("fl_stall", bus.fetch_stall, 1'b0);
      cyc(1'b1, 1'b0);
      chkb("fl_n1_valid", bus.id_valid, 1'b0);
      cyc(1'b1, 1'b0);
      chkb("fl_n2_valid", bus.id_valid, 1'b0);
      target = 32'h200;
      cyc(1'b1, 1'b1);
      chkb("fl_n3_valid", bus.id_valid, 1'b1);
      chk("fl_n3_pc", bus.id_pc, 32'h100);
      chk("fl_n3_inst", bus.id_inst, 32'h100 ^ K);
      cyc(1'b1, 1'b0);
      chkb("flpop_n1_valid", bus.id_valid, 1'b0);
      cyc(1'b1, 1'b0);
      chkb("flpop_n2_valid", bus.id_valid, 1'b0);
      cyc(1'b1, 1'b0);
      chk("flpop_n3_pc", bus.id_pc, 32'h200);
      chk("flpop_n3_inst", bus.id_inst, 32'h200 ^ K);
      for (int n = 0; n < 10000; n++) begin
         target = 32'($urandom_range(0, 4095)) << 2;
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         if (bus.id_valid) chkb("valid_has_entry", q.size() != 0, 1'b1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
